branch_predictor_bht: RTL and testbench

//  Dynamic branch predictor for the fetch stage: direct-mapped table of 2-bit saturating

---
 rtl/branch_predictor_bht.sv | 153 +++++++++++++++
 tb/tb_branch_predictor_bht.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
//   Fetch-stage dynamic branch predictor. A direct-mapped table of 2-bit
//   saturating counters, each paired with a tag and a branch target, is read
//   every cycle with the fetch PC. The fetch-stage prediction is registered
//   into decode as predict_taken_id, so the hazard unit can compare it with
//   the resolved outcome. The table is trained from decode when a branch or
//   jump resolves.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pc_if               PC of the instruction being fetched
//   pc_enable           fetch advance enable (0 = fetch stalled)
//   flush_ifid          IF/ID flush
//   predict_taken_if    fetch-stage taken prediction (combinational)
//   predict_target_if   next-PC candidate (combinational)
//   predict_taken_id    prediction carried by the instruction in decode
//   upd_valid           a branch/jump resolves this cycle
//   upd_pc              PC of the resolving instruction
//   upd_taken           resolved direction
//   upd_target          resolved target address
//   upd_mispredict      resolved outcome differed from the prediction
//   mispredict_count    saturating count of mispredictions
// ---------------------------------------------------------------------------
module branch_predictor_bht #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         pc_if,
  input  logic                pc_enable,
  input  logic                flush_ifid,
  output logic                predict_taken_if,
  output logic [31:0]         predict_target_if,
  output logic                predict_taken_id,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_mispredict,
  output logic [CNT_BITS-1:0] mispredict_count
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int TAG_LSB = INDEX_BITS + 2;
  localparam int TAG_MSB = INDEX_BITS + TAG_BITS + 1;

  // Counter saturating helpers: strongly-taken (11) and strongly-not-taken (00) stick.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : (c + 2'b01);
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : (c - 2'b01);
  endfunction

  // Table state
  logic                valid_r  [ENTRIES];
  logic [TAG_BITS-1:0] tag_r    [ENTRIES];
  logic [29:0]         target_r [ENTRIES];
  logic [1:0]          ctr_r    [ENTRIES];

  logic                predict_taken_id_r;
  logic [CNT_BITS-1:0] mispredict_count_r;

  // Lookup / update decode
  logic [INDEX_BITS-1:0] lkp_idx_s;
  logic [TAG_BITS-1:0]   lkp_tag_s;
  logic                  lkp_hit_s;
  logic                  lkp_taken_s;
  logic [INDEX_BITS-1:0] upd_idx_s;
  logic [TAG_BITS-1:0]   upd_tag_s;
  logic                  upd_hit_s;
  logic                  unused_s;

  // Address bits outside index/tag and the byte offset do not affect the table.
  assign unused_s = ^{upd_pc[31:TAG_MSB+1], upd_pc[1:0], upd_target[1:0]};

  // Fetch-side lookup: reads stored contents only, so same-cycle updates are not visible.
  always_comb begin
    lkp_idx_s         = pc_if[TAG_LSB-1:2];
    lkp_tag_s         = pc_if[TAG_MSB:TAG_LSB];
    lkp_hit_s         = valid_r[lkp_idx_s] && (tag_r[lkp_idx_s] == lkp_tag_s);
    lkp_taken_s       = lkp_hit_s && ctr_r[lkp_idx_s][1];
    if (lkp_taken_s) begin
      predict_target_if = {target_r[lkp_idx_s], 2'b00};
    end else begin
      predict_target_if = pc_if + 32'd4;
    end
  end

  assign predict_taken_if = lkp_taken_s;

  // Update-side decode of the resolving instruction's slot.
  always_comb begin
    upd_idx_s = upd_pc[TAG_LSB-1:2];
    upd_tag_s = upd_pc[TAG_MSB:TAG_LSB];
    upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
  end

  // Table training: hits move the counter, taken misses allocate weakly-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_BITS{1'b0}};
        target_r[i] <= 30'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit_s) begin
        if (upd_taken) begin
          ctr_r[upd_idx_s]    <= sat_inc(ctr_r[upd_idx_s]);
          target_r[upd_idx_s] <= upd_target[31:2];
        end else begin
          ctr_r[upd_idx_s]    <= sat_dec(ctr_r[upd_idx_s]);
        end
      end else if (upd_taken) begin
        valid_r[upd_idx_s]  <= 1'b1;
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= upd_target[31:2];
        ctr_r[upd_idx_s]    <= 2'b10;
      end
    end
  end

  // IF/ID prediction register: flush wins over advance; stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predict_taken_id_r <= 1'b0;
    end else if (flush_ifid) begin
      predict_taken_id_r <= 1'b0;
    end else if (pc_enable) begin
      predict_taken_id_r <= lkp_taken_s;
    end
  end

  // Mispredict statistics, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_count_r <= {CNT_BITS{1'b0}};
    end else if (upd_valid && upd_mispredict &&
                 (mispredict_count_r != {CNT_BITS{1'b1}})) begin
      mispredict_count_r <= mispredict_count_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign predict_taken_id = predict_taken_id_r;
  assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        pc_enable;
  logic        flush_ifid;
  logic        predict_taken_if;
  logic [31:0] predict_target_if;
  logic        predict_taken_id;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [15:0] mispredict_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_if             (pc_if),
    .pc_enable         (pc_enable),
    .flush_ifid        (flush_ifid),
    .predict_taken_if  (predict_taken_if),
    .predict_target_if (predict_target_if),
    .predict_taken_id  (predict_taken_id),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_taken         (upd_taken),
    .upd_target        (upd_target),
    .upd_mispredict    (upd_mispredict),
    .mispredict_count  (mispredict_count)
  );

  // Reference model: 64 slots, counter kept as an integer strength 0..3.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  bit          m_id;
  int unsigned m_cnt;

  function automatic int unsigned slot_of(logic [31:0] pc);
    return (pc >> 2) % 64;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return (pc >> 8) % 256;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc);
    return m_taken(pc) ? m_tgt[slot_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'd0;
      m_ctr[i]   = 1;
    end
    m_id  = 1'b0;
    m_cnt = 0;
  endtask

  // Advance the model by one rising edge using the inputs present before it.
  task automatic model_edge();
    bit p;
    int unsigned s;
    p = m_taken(pc_if);
    if (flush_ifid) m_id = 1'b0;
    else if (pc_enable) m_id = p;
    if (upd_valid) begin
      s = slot_of(upd_pc);
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_tgt[s] = upd_target & 32'hFFFF_FFFC;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[s] = 1'b1;
        m_tag[s]   = tag_of(upd_pc);
        m_tgt[s]   = upd_target & 32'hFFFF_FFFC;
        m_ctr[s]   = 2;
      end
      if (upd_mispredict && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("taken_if",  {31'd0, predict_taken_if}, {31'd0, m_taken(pc_if)});
    chk("target_if", predict_target_if, m_target(pc_if));
    chk("taken_id",  {31'd0, predict_taken_id}, {31'd0, m_id});
    chk("count",     {16'd0, mispredict_count}, m_cnt);
  endtask

  task automatic neg();
    @(negedge clk);
    check_all();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_upd(logic [31:0] pc, bit t, logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = t;
    upd_target = tgt;
    neg();
    edge_();
    upd_valid  = 1'b0;
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] p;
    p = $urandom;
    if ($urandom_range(0, 15) != 0) begin
      p[15:8] = 8'($urandom_range(0, 3));
      p[7:2]  = 6'($urandom_range(0, 7));
    end else if ($urandom_range(0, 1) == 0) begin
      p[31:2] = 30'h3FFF_FFFF;
    end
    return p;
  endfunction

  initial begin
    rst_n = 1'b0; pc_if = 32'h100; pc_enable = 1'b1; flush_ifid = 1'b0;
    upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0; upd_target = 32'd0;
    upd_mispredict = 1'b0;
    model_reset();

    // 1: reset state
    neg();
    chk("rst_taken",  {31'd0, predict_taken_if}, 32'd0);
    chk("rst_target", predict_target_if, 32'h104);
    chk("rst_count",  {16'd0, mispredict_count}, 32'd0);
    chk("rst_id",     {31'd0, predict_taken_id}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 2: allocate, no same-cycle bypass, then hit
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
    neg();
    chk("no_bypass", {31'd0, predict_taken_if}, 32'd0);
    edge_();
    upd_valid = 1'b0;
    neg();
    chk("t2_taken", {31'd0, predict_taken_if}, 32'd1);
    chk("t2_tgt", predict_target_if, 32'h200);
    edge_();
    pc_if = 32'h104;
    neg();
    chk("t2_next", {31'd0, predict_taken_if}, 32'd0);
    edge_();

    // 3: saturate up, then walk down to 00
    pc_if = 32'h100;
    repeat (3) do_upd(32'h100, 1'b1, 32'h200);
    repeat (2) do_upd(32'h100, 1'b0, 32'h0);
    neg();
    chk("t3_ctr01", {31'd0, predict_taken_if}, 32'd0);
    edge_();
    repeat (2) do_upd(32'h100, 1'b0, 32'h0);
    neg();
    chk("t3_ctr00", {31'd0, predict_taken_if}, 32'd0);
    edge_();

    // 4: aliasing and eviction
    repeat (2) do_upd(32'h100, 1'b1, 32'h180);
    neg();
    chk("t4_hit_tgt", predict_target_if, 32'h180);
    edge_();
    pc_if = 32'h200;
    neg();
    chk("t4_alias_taken", {31'd0, predict_taken_if}, 32'd0);
    chk("t4_alias_tgt", predict_target_if, 32'h204);
    edge_();
    do_upd(32'h200, 1'b1, 32'h240);
    pc_if = 32'h100;
    neg();
    chk("t4_evicted", {31'd0, predict_taken_if}, 32'd0);
    edge_();

    // 5: ID register hold / flush / advance
    pc_if = 32'h200;
    neg(); edge_();
    pc_enable = 1'b0; pc_if = 32'h300;
    repeat (3) begin
      neg();
      chk("t5_hold", {31'd0, predict_taken_id}, 32'd1);
      edge_();
    end
    flush_ifid = 1'b1;
    neg(); edge_();
    flush_ifid = 1'b0;
    neg();
    chk("t5_flush", {31'd0, predict_taken_id}, 32'd0);
    edge_();
    pc_enable = 1'b1; pc_if = 32'h200;
    neg(); edge_();
    neg();
    chk("t5_advance", {31'd0, predict_taken_id}, 32'd1);
    edge_();

    // 6: counter saturation, then asynchronous reset mid-cycle
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_taken = 1'b0; upd_pc = 32'h1000;
    repeat (65537) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    neg();
    chk("t6_sat", {16'd0, mispredict_count}, 32'h0000_FFFF);
    edge_();
    neg();
    chk("t6_sat_hold", {16'd0, mispredict_count}, 32'h0000_FFFF);
    edge_();
    upd_valid = 1'b0; upd_mispredict = 1'b0; pc_if = 32'h200;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_count", {16'd0, mispredict_count}, 32'd0);
    chk("t6_rst_id", {31'd0, predict_taken_id}, 32'd0);
    chk("t6_rst_taken", {31'd0, predict_taken_if}, 32'd0);
    chk("t6_rst_tgt", predict_target_if, 32'h204);
    #1 rst_n = 1'b1;
    neg(); edge_();

    // Randomized traffic against the model
    repeat (3000) begin
      pc_if          = rnd_pc();
      pc_enable      = ($urandom_range(0, 3) != 0);
      flush_ifid     = ($urandom_range(0, 7) == 0);
      upd_valid      = ($urandom_range(0, 1) == 1);
      upd_pc         = rnd_pc();
      upd_taken      = ($urandom_range(0, 2) != 0);
      upd_target     = $urandom;
      upd_mispredict = ($urandom_range(0, 1) == 1);
      neg();
      edge_();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
